// File: rtl/secded74_pkg.sv
// Shared definitions for the (7,4) Hamming SECDED codec: bit positions,
// syndrome/classification helpers and the error-class type.
package secded74_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Codeword bit index = Hamming position - 1.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P4 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2
    } err_class_e;

    // Syndrome {s4,s2,s1}; a nonzero value is the Hamming position of a single flipped bit.
    function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
        logic s1, s2, s4;
        s1 = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
        s2 = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
        s4 = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];
        return {s4, s2, s1};
    endfunction

    function automatic err_class_e classify(input logic [SYN_W-1:0] syn, input logic pchk);
        err_class_e cls;
        if (!pchk) begin
            cls = (syn == '0) ? CLEAN : DOUBLE;
        end else begin
            cls = SINGLE;
        end
        return cls;
    endfunction

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] code;
        code     = '0;
        code[D0] = data[0];
        code[D1] = data[1];
        code[D2] = data[2];
        code[D3] = data[3];
        code[P1] = data[0] ^ data[1] ^ data[3];
        code[P2] = data[0] ^ data[2] ^ data[3];
        code[P4] = data[1] ^ data[2] ^ data[3];
        return code;
    endfunction

    function automatic logic overall_parity(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

endpackage

// File: rtl/secded74_err_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module secded74_err_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: default assignment first so every path drives cnt_d -- no latch.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // NOTE: non-blocking for state so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/secded74_dec.sv
// Two-stage pipelined SECDED (7,4) decoder with valid/ready flow control
// and saturating single/double error statistics.
module secded74_dec
    import secded74_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [CODE_W-1:0]   i_hamming_code,
    input  logic                i_parity,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic [SYN_W-1:0]    o_syndrome,
    output logic                o_err_single,
    output logic                o_err_double,
    input  logic                i_cnt_clr,
    output logic [CNT_W-1:0]    o_cnt_single,
    output logic [CNT_W-1:0]    o_cnt_double
);

    // Stage 1: received word plus its check results.
    logic                s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0]   s1_code_q;
    logic [SYN_W-1:0]    s1_syn_q;
    logic                s1_pchk_q;

    // Stage 2: decoded result presented on the outputs.
    logic                s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SYN_W-1:0]    syn_q, syn_d;
    logic                single_q, single_d;
    logic                double_q, double_d;

    logic                s1_load, s2_load;
    logic                out_hs;
    logic [SYN_W-1:0]    in_syn;
    logic                in_pchk;
    err_class_e          s1_class;
    logic [CODE_W-1:0]   flip_mask;
    logic [CODE_W-1:0]   corrected;
    logic                unused_check_bits;

    assign s2_load = !s2_valid_q || i_ready;
    assign s1_load = !s1_valid_q || s2_load;
    assign o_ready = s1_load;
    assign out_hs  = s2_valid_q && i_ready;

    assign in_syn  = syndrome(i_hamming_code);
    assign in_pchk = overall_parity(i_hamming_code) ^ i_parity;

    assign s1_valid_d = s1_load ? i_valid : s1_valid_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // NOTE: payload flops carry no reset; s1_valid_q alone qualifies them.
    always_ff @(posedge i_clk) begin
        if (s1_load && i_valid) begin
            s1_code_q <= i_hamming_code;
            s1_syn_q  <= in_syn;
            s1_pchk_q <= in_pchk;
        end
    end

    always_comb begin
        s1_class  = classify(s1_syn_q, s1_pchk_q);
        flip_mask = '0;
        if ((s1_class == SINGLE) && (s1_syn_q != '0)) begin
            flip_mask = {{(CODE_W-1){1'b0}}, 1'b1} << (s1_syn_q - 3'd1);
        end
        corrected = s1_code_q ^ flip_mask;

        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        data_d     = data_q;
        syn_d      = syn_q;
        single_d   = single_q;
        double_d   = double_q;
        // Outputs only change when a real word moves in, so idle cycles hold the last result.
        if (s2_load && s1_valid_q) begin
            data_d   = {corrected[D3], corrected[D2], corrected[D1], corrected[D0]};
            syn_d    = s1_syn_q;
            single_d = (s1_class == SINGLE);
            double_d = (s1_class == DOUBLE);
        end
    end

    assign unused_check_bits = ^{corrected[P1], corrected[P2], corrected[P4]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            syn_q      <= '0;
            single_q   <= 1'b0;
            double_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            syn_q      <= syn_d;
            single_q   <= single_d;
            double_q   <= double_d;
        end
    end

    assign o_valid      = s2_valid_q;
    assign o_data       = data_q;
    assign o_syndrome   = syn_q;
    assign o_err_single = single_q;
    assign o_err_double = double_q;

    secded74_err_cnt #(.CNT_W(CNT_W)) u_cnt_single (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (out_hs && single_q),
        .o_cnt (o_cnt_single)
    );

    secded74_err_cnt #(.CNT_W(CNT_W)) u_cnt_double (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (out_hs && double_q),
        .o_cnt (o_cnt_double)
    );

    a_flags_exclusive : assert property (@(posedge i_clk) !(o_err_single && o_err_double));

endmodule

// File: tb/tb_secded74_dec.sv
// Self-checking bench: directed vector table, backpressure/saturation/reset
// sequences and constrained-random traffic against a Hamming reference model.
module tb_secded74_dec;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_parity, i_ready, i_cnt_clr;
    logic [6:0]  i_hamming_code;
    logic        o_ready, o_valid, o_err_single, o_err_double;
    logic [3:0]  o_data;
    logic [2:0]  o_syndrome;
    logic [15:0] o_cnt_single, o_cnt_double;
    logic        d2_ready, d2_valid, d2_err_single, d2_err_double;
    logic [3:0]  d2_data;
    logic [2:0]  d2_syndrome;
    logic [1:0]  d2_cnt_single, d2_cnt_double;

    always #5 clk = ~clk;

    secded74_dec dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_hamming_code(i_hamming_code), .i_parity(i_parity), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_syndrome(o_syndrome),
        .o_err_single(o_err_single), .o_err_double(o_err_double),
        .i_cnt_clr(i_cnt_clr), .o_cnt_single(o_cnt_single), .o_cnt_double(o_cnt_double)
    );

    secded74_dec #(.CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(d2_ready),
        .i_hamming_code(i_hamming_code), .i_parity(i_parity), .o_valid(d2_valid),
        .i_ready(i_ready), .o_data(d2_data), .o_syndrome(d2_syndrome),
        .o_err_single(d2_err_single), .o_err_double(d2_err_double),
        .i_cnt_clr(i_cnt_clr), .o_cnt_single(d2_cnt_single), .o_cnt_double(d2_cnt_double)
    );

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       single;
        logic       dbl;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc_cyc;
    } sb_t;

    typedef struct {
        logic [6:0] code;
        logic       par;
        logic [3:0] data;
        logic [2:0] syn;
        logic       single;
        logic       dbl;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    sb_t  sb[$];
    exp_t last_out;
    int   m_cs16, m_cd16, m_cs2, m_cd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: syndrome is the XOR of the positions of all set bits.
    function automatic exp_t model_decode(input logic [6:0] code, input logic par);
        exp_t       e;
        int         s;
        logic       pchk;
        logic [6:0] fixed;
        s    = 0;
        pchk = par;
        for (int i = 0; i < 7; i++) begin
            if (code[i]) begin
                s    = s ^ (i + 1);
                pchk = ~pchk;
            end
        end
        fixed = code;
        if (s != 0 && pchk) fixed[s-1] = ~fixed[s-1];
        e.syn    = s[2:0];
        e.single = pchk;
        e.dbl    = (s != 0) && !pchk;
        e.data   = {fixed[6], fixed[5], fixed[4], fixed[2]};
        return e;
    endfunction

    function automatic logic [6:0] model_encode(input logic [3:0] d);
        logic [6:0] c;
        logic       pb;
        c    = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        for (int k = 0; k < 3; k++) begin
            pb = 1'b0;
            for (int j = 3; j <= 7; j++) begin
                if ((j & (1 << k)) != 0 && j != 4) pb = pb ^ c[j-1];
            end
            c[(1 << k) - 1] = pb;
        end
        return c;
    endfunction

    task automatic cmp_out(input exp_t e);
        check("o_data", o_data, e.data);
        check("o_syndrome", o_syndrome, e.syn);
        check("o_err_single", o_err_single, e.single);
        check("o_err_double", o_err_double, e.dbl);
        check("w2_o_data", d2_data, e.data);
        check("w2_o_syndrome", d2_syndrome, e.syn);
        check("w2_o_err_single", d2_err_single, e.single);
        check("w2_o_err_double", d2_err_double, e.dbl);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [6:0] code, input logic par,
                         input logic rdy, input logic clr, input logic rst,
                         output logic accepted);
        logic exp_valid, exp_ready;
        @(posedge clk);
        #1;
        cyc++;
        i_valid        = v;
        i_hamming_code = code;
        i_parity       = par;
        i_ready        = rdy;
        i_cnt_clr      = clr;
        i_rst          = rst;
        @(negedge clk);
        exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc_cyc + 2);
        exp_ready = (sb.size() < 2) || rdy;
        check("o_valid", o_valid, exp_valid);
        check("o_ready", o_ready, exp_ready);
        check("w2_o_valid", d2_valid, exp_valid);
        check("w2_o_ready", d2_ready, exp_ready);
        cmp_out(exp_valid ? sb[0].e : last_out);
        check("o_cnt_single", o_cnt_single, m_cs16);
        check("o_cnt_double", o_cnt_double, m_cd16);
        check("w2_o_cnt_single", d2_cnt_single, m_cs2);
        check("w2_o_cnt_double", d2_cnt_double, m_cd2);
        accepted = v && exp_ready && !rst;
        if (rst) begin
            sb.delete();
            last_out = '0;
            m_cs16 = 0; m_cd16 = 0; m_cs2 = 0; m_cd2 = 0;
        end else begin
            if (exp_valid && rdy) begin
                last_out = sb[0].e;
                sb.pop_front();
                if (last_out.single) begin
                    if (m_cs16 < 65535) m_cs16++;
                    if (m_cs2 < 3) m_cs2++;
                end
                if (last_out.dbl) begin
                    if (m_cd16 < 65535) m_cd16++;
                    if (m_cd2 < 3) m_cd2++;
                end
            end
            if (clr) begin
                m_cs16 = 0; m_cd16 = 0; m_cs2 = 0; m_cd2 = 0;
            end
            if (accepted) sb.push_back('{e: model_decode(code, par), acc_cyc: cyc});
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic       a;
        int         deliv;
        logic       sent;
        logic [2:0] seen[3];
        logic [6:0] rc;
        logic       rp;
        int         idx0, idx1;

        vecs[0] = '{7'h55, 1'b0, 4'hB, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{7'h45, 1'b0, 4'hB, 3'd5, 1'b1, 1'b0};
        vecs[2] = '{7'h56, 1'b0, 4'hB, 3'd3, 1'b0, 1'b1};
        vecs[3] = '{7'h55, 1'b1, 4'hB, 3'd0, 1'b1, 1'b0};
        vecs[4] = '{7'h00, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};
        vecs[5] = '{7'h7F, 1'b1, 4'hF, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{7'h15, 1'b0, 4'hB, 3'd7, 1'b1, 1'b0};
        vecs[7] = '{7'h7F, 1'b0, 4'hF, 3'd0, 1'b1, 1'b0};
        vecs[8] = '{7'h50, 1'b0, 4'hA, 3'd2, 1'b0, 1'b1};

        last_out = '0;
        m_cs16 = 0; m_cd16 = 0; m_cs2 = 0; m_cd2 = 0;
        i_rst = 1'b1; i_valid = 1'b0; i_hamming_code = '0; i_parity = 1'b0;
        i_ready = 1'b1; i_cnt_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state.
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        check("reset_o_ready", o_ready, 1);
        check("reset_o_valid", o_valid, 0);
        check("reset_o_data", o_data, 0);

        // Directed table: one word at a time, two-cycle latency.
        for (int i = 0; i < 9; i++) begin
            cycle(1, vecs[i].code, vecs[i].par, 1, 0, 0, a);
            check("tbl_accept", a, 1);
            cycle(0, 7'h00, 0, 1, 0, 0, a);
            check("tbl_latency_early", o_valid, 0);
            cycle(0, 7'h00, 0, 1, 0, 0, a);
            check("tbl_valid", o_valid, 1);
            check("tbl_data", o_data, vecs[i].data);
            check("tbl_syn", o_syndrome, vecs[i].syn);
            check("tbl_single", o_err_single, vecs[i].single);
            check("tbl_double", o_err_double, vecs[i].dbl);
        end
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        check("tbl_cnt_single", o_cnt_single, 4);
        check("tbl_cnt_double", o_cnt_double, 2);
        check("tbl_cnt2_single_sat", d2_cnt_single, 3);
        check("tbl_cnt2_double", d2_cnt_double, 2);

        // Backpressure: two words fill the pipe, the third is refused.
        cycle(1, 7'h45, 0, 0, 0, 0, a); check("bp_acc0", a, 1);
        cycle(1, 7'h56, 0, 0, 0, 0, a); check("bp_acc1", a, 1);
        cycle(1, 7'h15, 0, 0, 0, 0, a); check("bp_acc2_refused", a, 0);
        check("bp_o_ready_low", o_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 7'h15, 0, 0, 0, 0, a);
            check("bp_hold_valid", o_valid, 1);
            check("bp_hold_syn", o_syndrome, 5);
            check("bp_hold_data", o_data, 4'hB);
        end
        deliv = 0;
        sent  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(!sent, 7'h15, 0, 1, 0, 0, a);
            if (o_valid && deliv < 3) begin
                seen[deliv] = o_syndrome;
                deliv++;
            end
            if (a) sent = 1'b1;
        end
        check("bp_delivered", deliv, 3);
        check("bp_order0", seen[0], 5);
        check("bp_order1", seen[1], 3);
        check("bp_order2", seen[2], 7);

        // CNT_W=2 saturation, then clear colliding with an error handshake.
        for (int i = 0; i < 5; i++) cycle(1, 7'h45, 0, 1, 0, 0, a);
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        cycle(0, 7'h00, 0, 1, 1, 0, a);
        check("sat_valid_at_clr", o_valid, 1);
        check("sat_cnt2_single", d2_cnt_single, 3);
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        check("clr_cnt2_single", d2_cnt_single, 0);
        check("clr_cnt_single", o_cnt_single, 0);
        check("clr_cnt_double", o_cnt_double, 0);

        // Reset mid-stream discards in-flight words.
        for (int i = 0; i < 3; i++) cycle(1, 7'h55, 0, 1, 0, 0, a);
        cycle(1, 7'h55, 0, 1, 0, 1, a);
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_ready", o_ready, 1);
        check("rst_o_data", o_data, 0);
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        cycle(0, 7'h00, 0, 1, 0, 0, a);
        check("rst_discard", o_valid, 0);

        // Random traffic: random, clean, single-flip and double-flip words.
        for (int n = 0; n < 3000; n++) begin
            rc = model_encode(4'($urandom));
            rp = ^rc;
            case ($urandom_range(0, 3))
                0: begin rc = 7'($urandom); rp = 1'($urandom); end
                1: ;
                2: begin
                    idx0 = $urandom_range(0, 7);
                    if (idx0 == 7) rp = ~rp; else rc[idx0] = ~rc[idx0];
                end
                default: begin
                    idx0 = $urandom_range(0, 7);
                    idx1 = (idx0 + $urandom_range(1, 7)) % 8;
                    if (idx0 == 7) rp = ~rp; else rc[idx0] = ~rc[idx0];
                    if (idx1 == 7) rp = ~rp; else rc[idx1] = ~rc[idx1];
                end
            endcase
            cycle($urandom_range(0, 3) != 0, rc, rp, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0, a);
        end
        for (int i = 0; i < 4; i++) cycle(0, 7'h00, 0, 1, 0, 0, a);
        check("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
